pipe_reg: RTL

PIPE_REG -- requirements
Module: pipe_reg

---
 rtl/pipe_reg.sv | 58 +++++
 1 files changed

// File: rtl/pipe_reg.sv
// pipe_reg: DEPTH-stage valid/ready register pipeline with flush and synchronous reset.
// Define PIPE_REG_OCC_EN to build the occ stage-occupancy count; otherwise occ is tied to 0.
module pipe_reg #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 2,
   parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{1'b0}}
) (
   input  logic clk,
   input  logic rst,
   input  logic flush,
   input  logic in_valid,
   input  logic [WIDTH-1:0] in_data,
   output logic in_ready,
   output logic out_valid,
   output logic [WIDTH-1:0] out_data,
   input  logic out_ready,
   output logic [$clog2(DEPTH+1)-1:0] occ
);
   localparam int OW = $clog2(DEPTH+1);
   logic [DEPTH-1:0] v, rdy;
   logic [WIDTH-1:0] d [DEPTH];
   // Stage i is ready when out_ready is high or any stage from i onward is empty.
   always_comb
      for (int i = 0; i < DEPTH; i++) rdy[i] = out_ready | (|(~v >> i));
   assign in_ready = rdy[0] & ~flush;
   assign out_valid = v[DEPTH-1];
   assign out_data = d[DEPTH-1];
   for (genvar s = 0; s < DEPTH; s++) begin : g_st
      logic vi, vr;
      logic [WIDTH-1:0] di, dr;
      if (s == 0) begin : g_h
         assign vi = in_valid & in_ready;
         assign di = in_data;
      end else begin : g_b
         assign vi = v[s-1];
         assign di = d[s-1];
      end
      always_ff @(posedge clk)
         if (rst) begin
            vr <= 1'b0;
            dr <= RST_VAL;
         end else begin
            if (flush) vr <= 1'b0;
            else if (rdy[s]) vr <= vi;
            if (!flush && rdy[s] && vi) dr <= di;
         end
      assign v[s] = vr;
      assign d[s] = dr;
   end
`ifdef PIPE_REG_OCC_EN
   always_comb begin
      occ = '0;
      for (int i = 0; i < DEPTH; i++) occ = occ + OW'(v[i]);
   end
`else
   assign occ = '0;
`endif
endmodule
